pio_port_bank: RTL and testbench
================================

# pio_port_bank

Parametrised bank of 6529-style quasi-bidirectional 8-bit parallel ports on the C16 CPU/TED bus, replacing single-channel keyport instances. Each channel keeps the wired-AND readback of the 6529. Each channel also adds the following, none of which the 6529 has:
- input synchronisation;
- a configurable glitch filter;
- per-bit edge detection with selectable polarity;
- a maskable interrupt, wired-AND onto the shared active-low IRQ line.

## Interface
Parameters:
- NUM_PORTS, 2: number of 8-bit channels; power of two, 1..8.
- BASE_ADDR, 16'hFD30: first bus address of the register window; aligned to 4*NUM_PORTS.
- SYNC_STAGES, 2: synchroniser depth on port_in, 2..4.
- FILTER_CYCLES, 0: extra consecutive CLK28 edges an input must differ before it is accepted; 0..255. 0 disables filtering.

Ports:
- CLK28 in 1: system clock.
- RESET in 1: reset; synchronous, active-high.
- bus_en in 1: one-CLK28 CPU cycle strobe (cpuenable qualified with !WAIT).
- addr in 16: C16 address bus.
- rw in 1: 1 = read, 0 = write.
- din in 8: C16 data bus to the block.
- dout out 8: read data; 8'hFF when not selected, for wired-AND onto the data bus.
- port_in in 8*NUM_PORTS: pin inputs; channel i occupies bits [8i+7:8i].
- port_out out 8*NUM_PORTS: output latches; open-collector semantics.
- irq_n out 1: active-low interrupt, registered.

## Operation
Register map:
- Window: BASE_ADDR .. BASE_ADDR+4*NUM_PORTS-1.
- Channel index i = (addr-BASE_ADDR)>>2.
- Register offset r = addr[1:0].

Registers per channel:
- r=0 DATA:
  - Write loads the output latch.
  - Read returns latch & sync_in, where sync_in is the last synchroniser stage (6529 readback).
- r=1 IMASK: R/W. Bit set enables that bit's status onto irq_n.
- r=2 ISTAT:
  - Read returns the edge status bits.
  - Write 1 clears the corresponding bit; write 0 has no effect.
- r=3 EDGE: R/W polarity select, per bit. 0 = falling edge sets status, 1 = rising edge sets status.

Bus rules:
- Writes commit only on a CLK28 edge where bus_en=1, rw=0 and addr is in the window.
- Reads are combinational from registers whenever addr is in the window and rw=1, independent of bus_en.
- Outside the window, dout=8'hFF and no state changes.

Input path, per bit:
- SYNC_STAGES flip-flops produce s.
- Filter holds a value filt and a counter cnt.
  - If s==filt: cnt<=0.
  - If s!=filt on this edge and the previous FILTER_CYCLES edges (FILTER_CYCLES+1 consecutive): filt<=s and cnt<=0.
  - Otherwise cnt increments.
- Edge detect: on the edge where filt updates, set ISTAT bit if the new value matches the polarity (0→1 with EDGE=1, 1→0 with EDGE=0).
- A set and a W1C of the same bit on the same edge: the set wins.

Interrupt:
- irq_n <= ~|(ISTAT & IMASK) over all channels, registered one edge after the cause.
- Writing IMASK or clearing ISTAT deasserts irq_n one edge later.

Reset values:
- port_out = all 1s.
- Synchroniser flops = 1, filt = 1, cnt = 0.
- IMASK = 0, ISTAT = 0, EDGE = 0.
- irq_n = 1.
- dout follows addr; it is combinational.

## Timing
- DATA write at edge W: port_out changes at W (visible after W). A DATA read in the following cycle returns the new latch ANDed with the pins.
- Pin change first captured at edge E0:
  - s valid after E0+SYNC_STAGES-1.
  - filt and ISTAT update at E0+SYNC_STAGES+FILTER_CYCLES.
  - irq_n falls at E0+SYNC_STAGES+FILTER_CYCLES+1.
- Glitch rule: a change at s lasting ≤ FILTER_CYCLES edges is discarded. cnt returns to 0 and no status is set.
- Reset: RESET sampled high at any edge restores all reset values at that edge, including mid-filter count and pending irq. No latched edge survives reset.
- A write with bus_en=0 is ignored. Repeated bus_en pulses during one write cycle re-apply the same value. This is idempotent for DATA/IMASK/EDGE, and for ISTAT W1C.

## Test plan
- Reset and DATA readback:
  - After RESET: port_out=16'hFFFF, irq_n=1.
  - Write 8'h5A to FD30 with bus_en.
  - port_out[7:0]=5A on the next cycle.
  - With port_in[7:0]=8'hF0, a read of FD30 returns 8'h50.
- Falling-edge irq (SYNC_STAGES=2, FILTER_CYCLES=0):
  - Set FD31=01.
  - Drive port_in[0] 1→0 captured at E0.
  - FD32 reads 01 from E0+2; irq_n=0 at E0+3.
  - Write 01 to FD32: irq_n=1 one edge later.
- Glitch filter (FILTER_CYCLES=3):
  - A 3-cycle low pulse on port_in[8] leaves FD36=00 and irq_n=1.
  - A 4-cycle low pulse sets FD36=01 at E0+5.
- Rising polarity and masking:
  - With FD37=80, FD35=00, a rising edge on bit 15 sets FD36=80 but irq_n stays 1.
  - Writing FD35=80 drives irq_n=0 on the next edge.
- Simultaneous set/clear and bus_en gating:
  - A W1C to FD32 on the same edge as a new edge event on that bit leaves the bit set.
  - A write with bus_en=0 changes nothing.
  - An out-of-window address gives dout=FF.
- Reset mid-operation:
  - Assert RESET while cnt is partway and irq_n=0.
  - At the next edge: irq_n=1, all registers at reset values.
  - A subsequent stable input produces no spurious status.

Source files
------------

// File: rtl/pio_port_bank_if.sv
// CPU/TED-side register bus for pio_port_bank: one-cycle strobe, address, direction, data.
// dout idles at 8'hFF so several slaves can be wired-ANDed onto the data bus.
interface pio_port_bank_if;
  logic        bus_en;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  din;
  logic [7:0]  dout;

  modport master (
    output bus_en,
    output addr,
    output rw,
    output din,
    input  dout
  );

  modport slave (
    input  bus_en,
    input  addr,
    input  rw,
    input  din,
    output dout
  );
endinterface

// File: rtl/pio_port_bank.sv
// Bank of 6529-style quasi-bidirectional 8-bit ports with input synchronisation, glitch
// filtering, per-bit edge capture and a maskable, wired-AND active-low interrupt.
module pio_port_bank #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter logic [15:0] BASE_ADDR     = 16'hFD30,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0
) (
  input  logic                   CLK28,
  input  logic                   RESET,
  pio_port_bank_if.slave         bus,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic                   irq_n
);

  localparam int unsigned W       = 8 * NUM_PORTS;
  localparam int unsigned IdxW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [15:0] WinSize = 16'(4 * NUM_PORTS);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0][7:0]             cnt_q, cnt_d;
  logic [W-1:0]                  filt_q, filt_d;
  logic [W-1:0]                  out_q, out_d;
  logic [W-1:0]                  imask_q, imask_d;
  logic [W-1:0]                  istat_q, istat_d;
  logic [W-1:0]                  pol_q, pol_d;
  logic                          irq_n_q, irq_n_d;

  logic [W-1:0]    s;
  logic [W-1:0]    upd;
  logic [W-1:0]    set;
  logic [W-1:0]    w1c;
  logic [15:0]     off;
  logic            in_win;
  logic            wr_en;
  logic [IdxW-1:0] ch;
  logic [1:0]      ra;
  logic [7:0]      rdata;

  // Window check on the wrapped offset covers both the below- and above-window cases.
  assign off    = bus.addr - BASE_ADDR;
  assign in_win = (off < WinSize);
  assign ch     = off[IdxW+1:2];
  assign ra     = off[1:0];
  assign wr_en  = bus.bus_en && !bus.rw && in_win;
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], port_in};

    filt_d = filt_q;
    cnt_d  = cnt_q;
    upd    = '0;
    for (int b = 0; b < W; b++) begin
      if (s[b] == filt_q[b]) begin
        cnt_d[b] = 8'd0;
      end else if (cnt_q[b] == 8'(FILTER_CYCLES)) begin
        filt_d[b] = s[b];
        cnt_d[b]  = 8'd0;
        upd[b]    = 1'b1;
      end else begin
        cnt_d[b] = cnt_q[b] + 8'd1;
      end
    end

    out_d   = out_q;
    imask_d = imask_q;
    pol_d   = pol_q;
    w1c     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (wr_en && (ch == IdxW'(i))) begin
        unique case (ra)
          2'd0: out_d[i*8 +: 8]   = bus.din;
          2'd1: imask_d[i*8 +: 8] = bus.din;
          2'd2: w1c[i*8 +: 8]     = bus.din;
          2'd3: pol_d[i*8 +: 8]   = bus.din;
        endcase
      end
    end

    // Accepted value equal to the polarity bit is the selected edge; a set beats a same-edge clear.
    set     = upd & ~(s ^ pol_q);
    istat_d = (istat_q & ~w1c) | set;
    irq_n_d = ~|(istat_q & imask_q);
  end

  always_comb begin
    rdata = 8'hFF;
    if (in_win && bus.rw) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (ch == IdxW'(i)) begin
          unique case (ra)
            2'd0: rdata = out_q[i*8 +: 8] & s[i*8 +: 8];
            2'd1: rdata = imask_q[i*8 +: 8];
            2'd2: rdata = istat_q[i*8 +: 8];
            2'd3: rdata = pol_q[i*8 +: 8];
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK28) begin
    if (RESET) begin
      sync_q  <= '1;
      filt_q  <= '1;
      cnt_q   <= '0;
      out_q   <= '1;
      imask_q <= '0;
      istat_q <= '0;
      pol_q   <= '0;
      irq_n_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      imask_q <= imask_d;
      istat_q <= istat_d;
      pol_q   <= pol_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign bus.dout = rdata;
  assign port_out = out_q;
  assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_pio_port_bank.sv
// Bench for pio_port_bank: an unfiltered instance and a FILTER_CYCLES=3 instance share one
// bus stream; expected values are queued as stimulus is driven and popped at observation.
module tb_pio_port_bank;

  logic        CLK28 = 1'b0;
  logic        RESET;
  logic [15:0] pin0, pin3, pout0, pout3;
  logic        irq0, irq3;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs, want;
  logic [7:0]  d;

  always #5 CLK28 = ~CLK28;

  pio_port_bank_if bus0 ();
  pio_port_bank_if bus3 ();

  assign bus3.bus_en = bus0.bus_en;
  assign bus3.addr   = bus0.addr;
  assign bus3.rw     = bus0.rw;
  assign bus3.din    = bus0.din;

  pio_port_bank #(
    .NUM_PORTS    (2),
    .BASE_ADDR    (16'hFD30),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(0)
  ) dut0 (
    .CLK28   (CLK28),
    .RESET   (RESET),
    .bus     (bus0),
    .port_in (pin0),
    .port_out(pout0),
    .irq_n   (irq0)
  );

  pio_port_bank #(
    .NUM_PORTS    (2),
    .BASE_ADDR    (16'hFD30),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(3)
  ) dut3 (
    .CLK28   (CLK28),
    .RESET   (RESET),
    .bus     (bus3),
    .port_in (pin3),
    .port_out(pout3),
    .irq_n   (irq3)
  );

  task automatic tick();
    @(posedge CLK28);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Write commits on the next rising edge; returns just after it.
  task automatic wr(input logic [15:0] a, input logic [7:0] v);
    bus0.addr   = a;
    bus0.din    = v;
    bus0.rw     = 1'b0;
    bus0.bus_en = 1'b1;
    tick();
    bus0.bus_en = 1'b0;
    bus0.rw     = 1'b1;
  endtask

  task automatic rd(input int which, input logic [15:0] a, output logic [7:0] v);
    bus0.addr = a;
    bus0.rw   = 1'b1;
    #1;
    v = (which == 0) ? bus0.dout : bus3.dout;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    pin0 = 16'hFFFF;
    pin3 = 16'hFFFF;
    bus0.bus_en = 1'b0;
    bus0.rw = 1'b1;
    bus0.addr = 16'h0000;
    bus0.din = 8'h00;
    ticks(2);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    obs = pout0; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_port_out got %h want %h", obs, want); end
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_irq_n got %h want %h", obs, want); end
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_istat got %h want %h", obs, want); end
    rd(0, 16'hFD33, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_edge got %h want %h", obs, want); end
    RESET = 1'b0;
  endtask

  task automatic test_data();
    wr(16'hFD30, 8'h5A);
    exp_q.push_back(16'h005A);
    exp_q.push_back(16'h005A);
    obs = {8'h00, pout0[7:0]}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL data_latch got %h want %h", obs, want); end
    rd(0, 16'hFD30, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL data_read_pins_high got %h want %h", obs, want); end
    pin0[7:0] = 8'hF0;
    exp_q.push_back(16'h0050);
    ticks(2);
    rd(0, 16'hFD30, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL data_readback_and got %h want %h", obs, want); end
    // Low nibble fell with default falling polarity; rising back must not add status.
    pin0[7:0] = 8'hFF;
    exp_q.push_back(16'h000F);
    exp_q.push_back(16'h0000);
    ticks(4);
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL istat_falls got %h want %h", obs, want); end
    wr(16'hFD32, 8'hFF);
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL istat_w1c_all got %h want %h", obs, want); end
  endtask

  task automatic test_fall_irq();
    wr(16'hFD31, 8'h01);
    pin0[0] = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    tick();
    tick();
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL fall_istat_e1 got %h want %h", obs, want); end
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL fall_irq_e1 got %h want %h", obs, want); end
    tick();
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL fall_istat_e2 got %h want %h", obs, want); end
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL fall_irq_e2 got %h want %h", obs, want); end
    tick();
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL fall_irq_e3 got %h want %h", obs, want); end
    wr(16'hFD32, 8'h01);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL w1c_irq_same_edge got %h want %h", obs, want); end
    tick();
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL w1c_irq_next_edge got %h want %h", obs, want); end
  endtask

  task automatic test_glitch();
    pin3[8] = 1'b0;
    ticks(3);
    pin3[8] = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    ticks(5);
    rd(3, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL glitch3_istat got %h want %h", obs, want); end
    obs = {15'h0, irq3}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL glitch3_irq got %h want %h", obs, want); end
    pin3[8] = 1'b0;
    ticks(4);
    pin3[8] = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    tick();
    rd(3, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL pulse4_e4 got %h want %h", obs, want); end
    tick();
    rd(3, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL pulse4_e5 got %h want %h", obs, want); end
    ticks(6);
    wr(16'hFD36, 8'h01);
    rd(3, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL pulse4_cleared got %h want %h", obs, want); end
  endtask

  task automatic test_rise_mask();
    wr(16'hFD37, 8'h80);
    wr(16'hFD35, 8'h00);
    pin0[15] = 1'b0;
    exp_q.push_back(16'h0000);
    ticks(4);
    rd(0, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rise_ignores_fall got %h want %h", obs, want); end
    pin0[15] = 1'b1;
    exp_q.push_back(16'h0080);
    exp_q.push_back(16'h0001);
    ticks(4);
    rd(0, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rise_istat got %h want %h", obs, want); end
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rise_masked_irq got %h want %h", obs, want); end
    wr(16'hFD35, 8'h80);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL unmask_same_edge got %h want %h", obs, want); end
    tick();
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL unmask_next_edge got %h want %h", obs, want); end
    wr(16'hFD36, 8'h80);
    tick();
    exp_q.push_back(16'h0001);
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rise_cleared_irq got %h want %h", obs, want); end
    wr(16'hFD35, 8'h00);
  endtask

  task automatic test_set_clear();
    pin0[0] = 1'b1;
    exp_q.push_back(16'h0000);
    ticks(4);
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rising_no_status got %h want %h", obs, want); end
    pin0[0] = 1'b0;
    tick();
    tick();
    // W1C commits on the same edge the falling edge is accepted.
    wr(16'hFD32, 8'h01);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL set_beats_clear got %h want %h", obs, want); end
    wr(16'hFD32, 8'h01);
    rd(0, 16'hFD32, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL later_clear got %h want %h", obs, want); end
    tick();
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL later_clear_irq got %h want %h", obs, want); end
  endtask

  task automatic test_gating();
    bus0.addr = 16'hFD30;
    bus0.din = 8'h00;
    bus0.rw = 1'b0;
    bus0.bus_en = 1'b0;
    tick();
    bus0.addr = 16'hFD31;
    bus0.din = 8'hFF;
    tick();
    bus0.rw = 1'b1;
    exp_q.push_back(16'h005A);
    exp_q.push_back(16'h0001);
    obs = {8'h00, pout0[7:0]}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL no_bus_en_data got %h want %h", obs, want); end
    rd(0, 16'hFD31, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL no_bus_en_imask got %h want %h", obs, want); end
    wr(16'hFD40, 8'h00);
    wr(16'hFD2F, 8'h00);
    exp_q.push_back(16'h5A5A);
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h00FF);
    obs = {pout0[7:0], pout3[7:0]}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL out_window_write got %h want %h", obs, want); end
    rd(0, 16'hFD40, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL dout_above_window got %h want %h", obs, want); end
    rd(3, 16'hFD2F, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL dout_below_window got %h want %h", obs, want); end
    bus0.addr = 16'hFD32;
    bus0.rw = 1'b0;
    #1;
    obs = {8'h00, bus0.dout}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL dout_write_cycle got %h want %h", obs, want); end
    bus0.rw = 1'b1;
  endtask

  task automatic test_reset_mid();
    wr(16'hFD35, 8'h01);
    pin3[8] = 1'b0;
    ticks(4);
    pin3[8] = 1'b1;
    pin3[9] = 1'b0;
    ticks(3);
    exp_q.push_back(16'h0000);
    obs = {15'h0, irq3}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL mid_irq_asserted got %h want %h", obs, want); end
    tick();
    RESET = 1'b1;
    pin0 = 16'hFFFF;
    pin3 = 16'hFFFF;
    tick();
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    obs = {15'h0, irq3}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_irq3 got %h want %h", obs, want); end
    obs = {15'h0, irq0}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_irq0 got %h want %h", obs, want); end
    obs = pout0; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_port_out got %h want %h", obs, want); end
    rd(3, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_istat got %h want %h", obs, want); end
    rd(3, 16'hFD35, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_imask got %h want %h", obs, want); end
    RESET = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h00FF);
    ticks(8);
    rd(3, 16'hFD36, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL post_rst_istat got %h want %h", obs, want); end
    rd(3, 16'hFD37, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL post_rst_edge got %h want %h", obs, want); end
    obs = {15'h0, irq3}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL post_rst_irq got %h want %h", obs, want); end
    rd(0, 16'hFD30, d);
    obs = {8'h00, d}; want = exp_q.pop_front(); checks++;
    if (obs !== want) begin errors++; $display("FAIL post_rst_data got %h want %h", obs, want); end
  endtask

  initial begin
    test_reset();
    test_data();
    test_fall_irq();
    test_glitch();
    test_rise_mask();
    test_set_clear();
    test_gating();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
